// File: rtl/cska_sub_seq_pkg.sv
// Shared types and defaults for the sequential carry-skip subtractor.
package cska_sub_seq_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int BLK_DEF   = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/cska_sub_seq_if.sv
// Producer/consumer handshake bundle for cska_sub_seq.
interface cska_sub_seq_if #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
);
  localparam int NBLK = WIDTH / BLK;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic [NBLK-1:0]  skip_mask;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, skip_mask
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, skip_mask
  );
endinterface

// File: rtl/cska_sub_seq_skip_block8.sv
// One combinational carry-skip block: ripple adder with a propagate-AND bypass.
module skip_block8 #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] x_i,
  input  logic [BLK-1:0] y_i,
  input  logic           cin_i,
  output logic [BLK-1:0] s_o,
  output logic           cout_o,
  output logic           skip_o
);
  logic [BLK-1:0] p;
  logic [BLK:0]   c;

  assign p    = x_i ^ y_i;
  assign c[0] = cin_i;

  for (genvar j = 0; j < BLK; j++) begin : g_fa
    assign c[j+1] = (x_i[j] & y_i[j]) | (c[j] & p[j]);
  end

  assign s_o    = p ^ c[BLK-1:0];
  // Full propagate means cout equals cin; take it directly, bypassing the chain.
  assign skip_o = &p;
  assign cout_o = skip_o ? cin_i : c[BLK];
endmodule

// File: rtl/cska_sub_seq.sv
// Multi-cycle a - b - bin, one carry-skip block per clock, LSB block first.
module cska_sub_seq
  import cska_sub_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BLK   = BLK_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  cska_sub_seq_if.slave bus
);
  localparam int NBLK = WIDTH / BLK;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, nb_q, diff_q;
  logic              carry_q, bout_q, ovf_q;
  logic [IDXW-1:0]   idx_q;
  logic [NBLK-1:0]   skip_q;
  logic [BLK-1:0]    blk_x, blk_y, blk_s;
  logic              blk_cout, blk_skip;
  logic              accept, last;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign last   = (idx_q == IDXW'(NBLK - 1));
  assign blk_x  = a_q[int'(idx_q)*BLK +: BLK];
  assign blk_y  = nb_q[int'(idx_q)*BLK +: BLK];

  skip_block8 #(.BLK(BLK)) u_blk (
    .x_i    (blk_x),
    .y_i    (blk_y),
    .cin_i  (carry_q),
    .s_o    (blk_s),
    .cout_o (blk_cout),
    .skip_o (blk_skip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last)         state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // Subtraction as a + ~b + ~bin: operands are stored pre-inverted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      nb_q    <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      skip_q  <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      nb_q    <= ~bus.b;
      carry_q <= ~bus.bin;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      skip_q  <= '0;
    end else if (state_q == RUN) begin
      diff_q[int'(idx_q)*BLK +: BLK] <= blk_s;
      skip_q[idx_q]                  <= blk_skip;
      carry_q                        <= blk_cout;
      if (last) begin
        idx_q  <= '0;
        bout_q <= ~blk_cout;
        ovf_q  <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (blk_s[BLK-1] != a_q[WIDTH-1]);
      end else begin
        idx_q  <= idx_q + IDXW'(1);
      end
    end
  end

  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.skip_mask = skip_q;
endmodule

// File: tb/tb_cska_sub_seq.sv
// Randomized bench for cska_sub_seq against an arithmetic reference model.
module tb_cska_sub_seq;
  localparam int WIDTH = 32;
  localparam int BLK   = 8;
  localparam int NBLK  = WIDTH / BLK;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  cska_sub_seq_if #(.WIDTH(WIDTH), .BLK(BLK)) bus ();

  cska_sub_seq #(.WIDTH(WIDTH), .BLK(BLK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic; a block skips exactly when its operand slices match.
  task automatic ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                           output logic [WIDTH-1:0] d, output logic bo, output logic ov,
                           output logic [NBLK-1:0] sm);
    logic [WIDTH:0] full;
    longint         s;
    full = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bin);
    d    = full[WIDTH-1:0];
    bo   = full[WIDTH];
    s    = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    ov   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    for (int i = 0; i < NBLK; i++) sm[i] = (a[i*BLK +: BLK] == b[i*BLK +: BLK]);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                       input int hold);
    logic [WIDTH-1:0] ed;
    logic             eb, eo;
    logic [NBLK-1:0]  es;
    int               n;
    bit               got;
    ref_model(a, b, bin, ed, eb, eo, es);
    bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.bin = 1'($urandom_range(0, 1));
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
      if (bus.out_valid) got = 1'b1;
      else chk("in_ready_run", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b0;
    chk("latency", 64'(n), 64'(NBLK));
    chk("diff", 64'(bus.diff), 64'(ed));
    chk("bout", 64'(bus.bout), 64'(eb));
    chk("ovf", 64'(bus.ovf), 64'(eo));
    chk("skip_mask", 64'(bus.skip_mask), 64'(es));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a = $urandom; bus.b = $urandom; bus.bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_diff", 64'(bus.diff), 64'(ed));
      chk("hold_flags", 64'({bus.bout, bus.ovf, bus.skip_mask}), 64'({eb, eo, es}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after", 64'(bus.in_ready), 64'd1);
    chk("out_valid_after", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_outs", 64'({bus.bout, bus.ovf, bus.skip_mask}), 64'd0);
    chk("rst_diff", 64'(bus.diff), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
    do_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 5);
    do_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1);

    // Reset while block 2 is being processed.
    bus.a = 32'h0000_1234; bus.b = 32'h0000_0001; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_diff", 64'(bus.diff), 64'd0);
    chk("midrst_skip", 64'(bus.skip_mask), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_out_valid", 64'(bus.out_valid), 64'd0);
    do_op(32'd10, 32'd20, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb[15:8] = ra[15:8];
      do_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cska_sub_seq.md
Name: cska_sub_seq

Overview:
- Multi-cycle WIDTH-bit subtractor that computes diff = a - b - bin.
- Processes one BLK-bit carry-skip block per clock, least significant block first.
- Runs as the inverse-operation companion to the combinational 8-bit carry-skip adder, sharing its block structure.
- Sits between a valid/ready producer and consumer in the datapath.
- Reports the borrow-out, signed overflow, and a per-block skip mask for observability.

Parameters:
- WIDTH, 32, operand width; must be a multiple of BLK.
- BLK, 8, bits per carry-skip block.
- NBLK, WIDTH/BLK, derived block count; not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when unsigned a < b + bin.
- ovf  output  1  signed two's-complement overflow.
- skip_mask  output  NBLK  bit i = 1 when block i propagate was all ones, so the carry bypassed the block.

Behaviour:
- Arithmetic: diff = a + ~b + ~bin.
  - Internal carry c0 = ~bin.
  - bout = ~carry out of the top block.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
- Per block i: P = a_i ^ ~b_i (BLK bits).
  - Sum = P ^ ripple carries.
  - Block carry-out = cin when &P; otherwise the ripple carry-out.
  - skip_mask[i] = &P.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready, latch a, ~b and carry = ~bin; clear idx, diff register and skip_mask; go to RUN.
  - RUN: each cycle, process block idx, write diff slice idx and skip_mask[idx], register carry-out, then idx++. When idx = NBLK-1 is processed, register bout and ovf and go to DONE.
  - DONE: out_valid = 1, and diff/bout/ovf/skip_mask are held stable. On out_ready, go to IDLE.
- Timing and latency:
  - Acceptance edge is T. out_valid rises after edge T+NBLK (4 for defaults).
  - With out_ready held high, in_ready returns one cycle after the handshake.
  - Throughput is one result per NBLK+2 cycles. There is no overlap.
- Handshake rules:
  - in_ready = (state == IDLE), decoded combinationally from the state register.
  - in_valid and operand changes in RUN/DONE are ignored. Operands are sampled only at acceptance.
  - out_valid never drops without out_ready.
  - out_ready while not in DONE has no effect.
- Reset:
  - rst_n low, at any time including mid-RUN: state = IDLE, idx = 0, all outputs 0 (in_ready = 1 as decoded from IDLE).
  - Any in-flight operation is discarded with no partial output.
- Width corner cases:
  - bin = 1 with a = b gives all ones and bout = 1.
  - Wrap-around is modulo 2^WIDTH.

Decomposition:
- Shared package: FSM state enum (IDLE, RUN, DONE) and default constants WIDTH = 32, BLK = 8.
- Sub-module skip_block8 (parameterised by BLK): combinational, inputs x, y, cin; outputs s, cout, skip.
  - Uses a full-adder ripple chain plus the propagate-AND skip mux.
  - One instance is reused each cycle via slice muxing on idx.

Test Plan:
- a=0x00000005, b=0x00000003, bin=0 -> diff=0x00000002, bout=0, ovf=0, skip_mask=4'b1110; out_valid exactly 4 cycles after acceptance.
- a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1, ovf=0, skip_mask=4'b1110.
- a=0x80000000, b=0x00000001, bin=0 -> diff=0x7FFFFFFF, bout=0, ovf=1, skip_mask=4'b0110.
- a=b=0x12345678, bin=1 -> diff=0xFFFFFFFF, bout=1, ovf=0, skip_mask=4'b1111 (full skip path).
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> outputs stable, in_ready=0; assert out_ready -> in_ready=1 next cycle, next operands accepted correctly.
- Assert rst_n=0 while processing block 2 -> out_valid=0, diff=0, skip_mask=0 immediately; after release, a=10, b=20, bin=0 -> diff=0xFFFFFFF6, bout=1.
